// File: rtl/sample_buffer_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_buffer_drain
// Purpose  : Walks the sample buffer entry by entry and serialises each
//            trace word plus its three expired-bit vectors onto a 32-bit
//            valid/ready stream, then commands a tracker clear.
// Revision : 1.0 - initial release
// ============================================================================
module sample_buffer_drain #(
    parameter int N_LINES    = 128,
    parameter int BW_BUFFER  = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [31:0]          count_i,
    output logic [BW_BUFFER-1:0] buf_addr_o,
    input  logic [127:0]         trace_i,
    input  logic [N_LINES-1:0]   expired_bits_0_i,
    input  logic [N_LINES-1:0]   expired_bits_1_i,
    input  logic [N_LINES-1:0]   expired_bits_2_i,
    output logic [31:0]          word_o,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic                 busy_o,
    output logic                 clear_o,
    output logic                 done_o
);

    localparam int c_WORDS = 4 + 3 * N_LINES / 32;
    localparam int c_SR_W  = 128 + 3 * N_LINES;
    localparam int c_WC_W  = $clog2(c_WORDS);

    localparam logic [c_WC_W-1:0] c_WORD_LAST = c_WC_W'(c_WORDS - 1);
    localparam logic [1:0]        c_WAIT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [31:0]       c_DEPTH     = 32'd1 << BW_BUFFER;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADDR  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_SEND  = 3'd3;
    localparam logic [2:0] c_NEXT  = 3'd4;
    localparam logic [2:0] c_CLEAR = 3'd5;

    logic [2:0]           state_q,    state_d;
    logic [BW_BUFFER:0]   idx_q,      idx_d;
    logic [BW_BUFFER:0]   n_q,        n_d;
    logic [BW_BUFFER-1:0] addr_q,     addr_d;
    logic [1:0]           wait_q,     wait_d;
    logic [c_WC_W-1:0]    wcnt_q,     wcnt_d;
    logic [c_SR_W-1:0]    sr_q,       sr_d;
    logic                 valid_q,    valid_d;
    logic                 busy_q,     busy_d;
    logic                 clear_q,    clear_d;
    logic                 done_q,     done_d;

    logic [BW_BUFFER:0]   w_n_start;
    logic [BW_BUFFER:0]   w_idx_inc;

    // Index is one bit wider than the address so a full buffer terminates.
    assign w_n_start = (count_i > c_DEPTH) ? c_DEPTH[BW_BUFFER:0] : count_i[BW_BUFFER:0];
    assign w_idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        wcnt_d  = wcnt_q;
        sr_d    = sr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        clear_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    n_d     = w_n_start;
                    idx_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (w_n_start != '0) ? c_ADDR : c_CLEAR;
                end
            end
            c_ADDR: begin
                wait_d  = '0;
                state_d = c_WAIT;
            end
            c_WAIT: begin
                if (wait_q == c_WAIT_LAST) begin
                    sr_d    = {expired_bits_2_i, expired_bits_1_i, expired_bits_0_i, trace_i};
                    wcnt_d  = '0;
                    valid_d = 1'b1;
                    state_d = c_SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            c_SEND: begin
                if (word_ready_i) begin
                    sr_d = sr_q >> 32;
                    if (wcnt_q == c_WORD_LAST) begin
                        valid_d = 1'b0;
                        state_d = c_NEXT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            c_NEXT: begin
                idx_d = w_idx_inc;
                if (w_idx_inc == n_q) begin
                    state_d = c_CLEAR;
                end else begin
                    addr_d  = w_idx_inc[BW_BUFFER-1:0];
                    state_d = c_ADDR;
                end
            end
            c_CLEAR: begin
                clear_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= c_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
            wcnt_q  <= '0;
            sr_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            wcnt_q  <= wcnt_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            clear_q <= clear_d;
            done_q  <= done_d;
        end
    end

    assign buf_addr_o   = addr_q;
    assign word_o       = sr_q[31:0];
    assign word_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign clear_o      = clear_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sample_buffer_drain
// Purpose  : Randomised bench for sample_buffer_drain with a word-queue
//            reference model and a per-cycle output compare process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_buffer_drain;

    localparam int NL    = 128;
    localparam int BW    = 8;
    localparam int LAT   = 1;
    localparam int DEPTH = 1 << BW;
    localparam int WPE   = 4 + 3 * NL / 32;

    typedef struct {
        logic [31:0]   w;
        logic [BW-1:0] a;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [31:0]   count_i = '0;
    logic [BW-1:0] buf_addr_o;
    logic [127:0]  trace_i;
    logic [NL-1:0] e0_i, e1_i, e2_i;
    logic [31:0]   word_o;
    logic          word_valid_o;
    logic          word_ready_i = 1'b1;
    logic          busy_o, clear_o, done_o;

    sample_buffer_drain #(
        .N_LINES    (NL),
        .BW_BUFFER  (BW),
        .RD_LATENCY (LAT)
    ) dut (
        .clock_i          (clk),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .count_i          (count_i),
        .buf_addr_o       (buf_addr_o),
        .trace_i          (trace_i),
        .expired_bits_0_i (e0_i),
        .expired_bits_1_i (e1_i),
        .expired_bits_2_i (e2_i),
        .word_o           (word_o),
        .word_valid_o     (word_valid_o),
        .word_ready_i     (word_ready_i),
        .busy_o           (busy_o),
        .clear_o          (clear_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    // Buffer memory with a synchronous read pipeline of LAT stages.
    logic [127:0]  mem_t  [0:DEPTH-1];
    logic [NL-1:0] mem_e0 [0:DEPTH-1];
    logic [NL-1:0] mem_e1 [0:DEPTH-1];
    logic [NL-1:0] mem_e2 [0:DEPTH-1];
    logic [127:0]  pipe_t  [0:LAT-1];
    logic [NL-1:0] pipe_e0 [0:LAT-1];
    logic [NL-1:0] pipe_e1 [0:LAT-1];
    logic [NL-1:0] pipe_e2 [0:LAT-1];

    always @(posedge clk) begin
        pipe_t[0]  <= mem_t[buf_addr_o];
        pipe_e0[0] <= mem_e0[buf_addr_o];
        pipe_e1[0] <= mem_e1[buf_addr_o];
        pipe_e2[0] <= mem_e2[buf_addr_o];
        for (int s = 1; s < LAT; s++) begin
            pipe_t[s]  <= pipe_t[s-1];
            pipe_e0[s] <= pipe_e0[s-1];
            pipe_e1[s] <= pipe_e1[s-1];
            pipe_e2[s] <= pipe_e2[s-1];
        end
    end
    assign trace_i = pipe_t[LAT-1];
    assign e0_i    = pipe_e0[LAT-1];
    assign e1_i    = pipe_e1[LAT-1];
    assign e2_i    = pipe_e2[LAT-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference model: the full expected word stream of a drain, plus the
    // busy/clear timing that follows from NEXT -> CLEAR -> IDLE.
    exp_t          q[$];
    logic          armed = 1'b0;
    logic          rst_chk = 1'b0;
    logic          active = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_pulse = 1'b0;
    int            cd = 0;
    int            gap = 0;
    logic          hold = 1'b0;
    logic [31:0]   hold_w = '0;
    int            xfers = 0;
    int            pulses = 0;
    logic [BW-1:0] last_addr = '0;
    logic [31:0]   log_w [0:63];
    logic [BW-1:0] log_a [0:63];

    task automatic push_drain(input int n);
        exp_t it;
        for (int e = 0; e < n; e++) begin
            it.a = BW'(e);
            for (int k = 0; k < 4; k++) begin
                it.w = mem_t[e][32*k +: 32];
                q.push_back(it);
            end
            for (int k = 0; k < NL / 32; k++) begin it.w = mem_e0[e][32*k +: 32]; q.push_back(it); end
            for (int k = 0; k < NL / 32; k++) begin it.w = mem_e1[e][32*k +: 32]; q.push_back(it); end
            for (int k = 0; k < NL / 32; k++) begin it.w = mem_e2[e][32*k +: 32]; q.push_back(it); end
        end
    endtask

    always @(negedge clk) begin
        logic lastx;
        logic accept;
        logic busy_n;
        logic pulse_n;
        int   n;
        lastx = 1'b0;
        if (armed) begin
            if (rst_chk) begin
                check("reset_outputs", {buf_addr_o, word_o, word_valid_o, busy_o, clear_o, done_o}, '0);
            end else begin
                check("busy", busy_o, exp_busy);
                check("clear_pulse", clear_o, exp_pulse);
                check("done_pulse", done_o, exp_pulse);
                if (clear_o) pulses++;
                if (hold) begin
                    check("hold_valid", word_valid_o, 1'b1);
                    check("hold_word", word_o, hold_w);
                end
                if (word_valid_o) begin
                    check("valid_has_data", q.size() != 0, 1'b1);
                    if (q.size() != 0 && word_ready_i) begin
                        check("word", word_o, q[0].w);
                        check("addr", buf_addr_o, q[0].a);
                        if (xfers < 64) begin
                            log_w[xfers] = word_o;
                            log_a[xfers] = buf_addr_o;
                        end
                        last_addr = buf_addr_o;
                        xfers++;
                        void'(q.pop_front());
                        if (q.size() == 0) lastx = 1'b1;
                    end
                end
                if (exp_busy && !word_valid_o) gap++;
                else gap = 0;
                if (gap > 30) begin
                    check("valid_gap", gap, 30);
                    gap = 0;
                end
            end
        end
        // Advance the model to the cycle after the coming clock edge.
        accept  = start_i && !active && !reset_i;
        busy_n  = exp_busy;
        pulse_n = 1'b0;
        hold    = word_valid_o && !word_ready_i;
        hold_w  = word_o;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                busy_n  = 1'b0;
                pulse_n = 1'b1;
                active  = 1'b0;
            end
        end
        if (lastx) cd = 2;
        if (accept) begin
            n = (count_i > 32'(DEPTH)) ? DEPTH : int'(count_i);
            push_drain(n);
            active = 1'b1;
            busy_n = 1'b1;
            if (n == 0) cd = 1;
        end
        rst_chk = 1'b0;
        if (reset_i) begin
            armed   = 1'b1;
            rst_chk = 1'b1;
            q.delete();
            active  = 1'b0;
            cd      = 0;
            gap     = 0;
            hold    = 1'b0;
            busy_n  = 1'b0;
            pulse_n = 1'b0;
        end
        exp_busy  = busy_n;
        exp_pulse = pulse_n;
    end

    int ready_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       word_ready_i = 1'b1;
            1:       word_ready_i = ~word_ready_i;
            default: word_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem_t[i]  = {$urandom, $urandom, $urandom, $urandom};
            mem_e0[i] = {$urandom, $urandom, $urandom, $urandom};
            mem_e1[i] = {$urandom, $urandom, $urandom, $urandom};
            mem_e2[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic clear_stats();
        xfers  = 0;
        pulses = 0;
    endtask

    task automatic do_start(input logic [31:0] cnt);
        start_i = 1'b1;
        count_i = cnt;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && pulses == 0; i++) tick();
        repeat (3) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1);
    end

    initial begin
        fill_mem();
        mem_t[0] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        mem_e0[0][31:0]   = 32'hE000_0001;
        mem_e2[0][127:96] = 32'hE200_0004;

        reset_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        check("idle_busy", busy_o, 1'b0);
        check("idle_valid", word_valid_o, 1'b0);

        // Three entries, ready held high.
        clear_stats();
        do_start(32'd3);
        wait_done(2000);
        check("n3_words", xfers, 48);
        check("n3_pulses", pulses, 1);
        check("n3_last_addr", last_addr, 2);
        check("n3_w0", log_w[0], 32'h1111_1111);
        check("n3_w3", log_w[3], 32'h4444_4444);
        check("n3_w4", log_w[4], 32'hE000_0001);
        check("n3_w15", log_w[15], 32'hE200_0004);
        check("n3_busy_after", busy_o, 1'b0);

        // Empty buffer: busy one cycle, pulse two cycles after start.
        clear_stats();
        do_start(32'd0);
        check("n0_busy", busy_o, 1'b1);
        check("n0_clear_early", clear_o, 1'b0);
        tick();
        check("n0_clear", clear_o, 1'b1);
        check("n0_done", done_o, 1'b1);
        check("n0_busy_low", busy_o, 1'b0);
        tick();
        check("n0_clear_end", clear_o, 1'b0);
        check("n0_words", xfers, 0);

        // One entry, ready toggling every cycle.
        ready_mode = 1;
        clear_stats();
        do_start(32'd1);
        wait_done(2000);
        check("n1_toggle_words", xfers, 16);
        check("n1_toggle_pulses", pulses, 1);

        // Count beyond the buffer depth saturates.
        ready_mode = 0;
        clear_stats();
        do_start(32'd5000);
        wait_done(10000);
        check("sat_words", xfers, DEPTH * WPE);
        check("sat_last_addr", last_addr, DEPTH - 1);
        check("sat_pulses", pulses, 1);

        // Reset while word 7 of entry 2 is presented.
        clear_stats();
        do_start(32'd3);
        for (int i = 0; i < 2000 && xfers < 2 * WPE + 7; i++) tick();
        check("reach_e2w7", xfers, 2 * WPE + 7);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("rst_valid", word_valid_o, 1'b0);
        check("rst_addr", buf_addr_o, 0);
        repeat (10) tick();
        check("rst_no_pulse", pulses, 0);
        clear_stats();
        do_start(32'd1);
        wait_done(2000);
        check("post_rst_words", xfers, 16);
        check("post_rst_addr0", log_a[0], 0);

        // Reset and start together: reset wins.
        clear_stats();
        reset_i = 1'b1;
        start_i = 1'b1;
        count_i = 32'd3;
        tick();
        reset_i = 1'b0;
        start_i = 1'b0;
        repeat (3) tick();
        check("rst_start_busy", busy_o, 1'b0);

        // Restart attempts during a drain are ignored.
        clear_stats();
        do_start(32'd2);
        repeat (5) tick();
        count_i = 32'd9;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (15) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(2000);
        check("restart_words", xfers, 2 * WPE);
        check("restart_pulses", pulses, 1);

        // Randomised drains with random back-pressure and fresh buffer data.
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            int cnt;
            cnt = $urandom_range(0, 7);
            fill_mem();
            clear_stats();
            do_start(32'(cnt));
            wait_done(3000);
            check("rand_words", xfers, cnt * WPE);
            check("rand_pulses", pulses, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_buffer_drain.md
SAMPLE_BUFFER_DRAIN -- requirements
Module: sample_buffer_drain

Interface
REQ-001 SHALL have parameter N_LINES, default 128, expired-bit vector width; legal values are multiples of 32, min 32.
REQ-002 SHALL have parameter BW_BUFFER, default 12, buffer address width (2^BW_BUFFER entries).
REQ-003 SHALL have parameter RD_LATENCY, default 1, cycles from buf_addr_o change to valid buffer read data (1..4).
REQ-004 clock_i  in  1  single clock; all logic on rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  one-cycle request to drain the buffer.
REQ-007 count_i  in  32  number of valid buffer entries (tracker count output).
REQ-008 buf_addr_o  out  BW_BUFFER  buffer read address.
REQ-009 trace_i  in  128  trace word read from buffer at buf_addr_o.
REQ-010 expired_bits_0_i / _1_i / _2_i  in  N_LINES each  expired-bit vectors read from buffer.
REQ-011 word_o  out  32  serialized output word.
REQ-012 word_valid_o  out  1  word_o valid.
REQ-013 word_ready_i  in  1  host accepts word_o; transfer when word_valid_o & word_ready_i.
REQ-014 busy_o  out  1  drain in progress.
REQ-015 clear_o  out  1  one-cycle pulse commanding tracker stall clear / pointer reset.
REQ-016 done_o  out  1  one-cycle pulse at drain completion.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, WAIT, SEND, NEXT, CLEAR.
REQ-018 IDLE: on start_i=1 SHALL latch N = min(count_i, 2^BW_BUFFER), set entry index 0, assert busy_o next cycle; go ADDR if N>0, else CLEAR.
REQ-019 start_i while busy_o=1 SHALL be ignored.
REQ-020 ADDR: buf_addr_o = entry index (low BW_BUFFER bits); SHALL go WAIT.
REQ-021 WAIT: SHALL hold RD_LATENCY cycles, then capture trace_i and all three expired vectors into a shift register in one cycle and go SEND.
REQ-022 Words per entry W = 4 + 3*N_LINES/32 (16 at default).
REQ-023 Word order: trace[31:0], trace[63:32], trace[95:64], trace[127:96], then expired_bits_0 LSW first, then _1, then _2.
REQ-024 SEND: word_valid_o=1; word_o and word_valid_o SHALL stay stable until accepted; advance one word per accepted cycle; back-to-back transfers with ready held high at 1 word/cycle.
REQ-025 After last word of entry accepted SHALL go NEXT, deasserting word_valid_o that cycle.
REQ-026 NEXT: increment index; if index == N go CLEAR, else ADDR.
REQ-027 CLEAR: clear_o=1 and done_o=1 for exactly one cycle, then IDLE with busy_o=0.
REQ-028 Entry index SHALL be BW_BUFFER+1 bits so N = 2^BW_BUFFER terminates without wrap; buf_addr_o wraps naturally only in its low bits.
REQ-029 count_i changes after latch SHALL not affect the drain in progress.
REQ-030 Buffer inputs SHALL be sampled only in the capture cycle of REQ-021.

Reset
REQ-031 reset_i=1 at any clock edge SHALL force IDLE; buf_addr_o=0, word_o=0, word_valid_o=0, busy_o=0, clear_o=0, done_o=0, index=0.
REQ-032 Reset mid-drain SHALL abort with no clear_o or done_o pulse; reset with start_i same cycle: reset wins.

Verification
REQ-033 count_i=3, ready=1, RD_LATENCY=1: 48 words total in order per REQ-023, buf_addr_o 0,1,2, one clear_o/done_o pulse, busy_o low after.
REQ-034 count_i=0, start_i: no word_valid_o; clear_o and done_o pulse 2 cycles after start; busy_o high 1 cycle.
REQ-035 count_i=1, ready toggled 1/0 each cycle: word_o stable while ready=0, 16 words accepted, none duplicated or lost.
REQ-036 count_i=5000, BW_BUFFER=12: exactly 4096 entries drained, last buf_addr_o=4095, single clear_o.
REQ-037 reset_i asserted during word 7 of entry 2: all outputs 0 next cycle, no clear_o; subsequent start_i with count_i=1 drains normally from address 0.
REQ-038 start_i pulsed again during drain with count_i=9 changed: drain completes with originally latched N, no restart.
